// File: rtl/lsu_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : lsu_ctrl_if
// Purpose  : Bundles the request, response and data-memory signals of the
//            load/store control stage.
// Ports    : req_*  - request handshake from execute (valid/ready)
//            resp_* - response handshake to writeback (valid/ready)
//            mem_*  - strobes/address/data to the byte-addressed memory
// Modports : slave  - the load/store controller
//            master - the surrounding environment (execute, writeback, memory)
// Revision : 1.0 - initial release
// ============================================================================
interface lsu_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;

    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_data;
    logic        resp_fault;

    logic        mem_read;
    logic        mem_write;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;

    modport slave (
        input  req_valid, req_store, req_funct3, req_addr, req_wdata,
        output req_ready,
        output resp_valid, resp_data, resp_fault,
        input  resp_ready,
        output mem_read, mem_write, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output req_valid, req_store, req_funct3, req_addr, req_wdata,
        input  req_ready,
        input  resp_valid, resp_data, resp_fault,
        output resp_ready,
        input  mem_read, mem_write, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/lsu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : lsu_ctrl
// Purpose  : Load/store control stage. Accepts one memory request at a time,
//            checks alignment/range/legality, drives the data memory strobes,
//            extends sub-word loads and performs read-modify-write for
//            sub-word stores (the memory only writes whole doublewords).
// Ports    : clk   - clock, rising edge
//            reset - asynchronous active-high reset
//            bus   - lsu_ctrl_if.slave (request, response, memory signals)
// Revision : 1.0 - initial release
// ============================================================================
module lsu_ctrl #(
    parameter int ADDR_BITS = 10
) (
    input wire         clk,
    input wire         reset,
    lsu_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        RMW_RD = 3'd2,
        WRITE  = 3'd3,
        RESP   = 3'd4
    } state_t;

    state_t      r_state;
    logic [2:0]  r_funct3;
    // Only the low word of store data is needed after acceptance: full
    // doubleword stores are forwarded straight into mem_wdata.
    logic [31:0] r_wdata;

    logic        r_req_ready;
    logic        r_resp_valid;
    logic [63:0] r_resp_data;
    logic        r_resp_fault;
    logic        r_mem_read;
    logic        r_mem_write;
    logic [63:0] r_mem_addr;
    logic [63:0] r_mem_wdata;

    logic [2:0]  w_mask;
    logic        w_misalign;
    logic        w_overflow;
    logic        w_high;
    logic        w_illegal;
    logic        w_fault;
    logic        w_accept;
    logic [63:0] w_load_ext;
    logic [63:0] w_merged;

    // ------------------------------------------------------------------
    // Request decode (evaluated on the live request while in IDLE)
    // ------------------------------------------------------------------
    always_comb begin
        w_mask = 3'd0;
        case (bus.req_funct3[1:0])
            2'b00:   w_mask = 3'd0;
            2'b01:   w_mask = 3'd1;
            2'b10:   w_mask = 3'd3;
            default: w_mask = 3'd7;
        endcase
    end

    assign w_misalign = |(bus.req_addr[2:0] & w_mask);
    // Last byte of the access must stay inside the implemented memory.
    assign w_overflow = ({1'b0, bus.req_addr[ADDR_BITS-1:0]}
                         + {{(ADDR_BITS-2){1'b0}}, w_mask})
                        > {1'b0, {ADDR_BITS{1'b1}}};
    assign w_high     = |bus.req_addr[63:ADDR_BITS];
    assign w_illegal  = bus.req_store ? bus.req_funct3[2]
                                      : (bus.req_funct3 == 3'b111);
    assign w_fault    = w_misalign | w_overflow | w_high | w_illegal;
    assign w_accept   = bus.req_valid & r_req_ready;

    // ------------------------------------------------------------------
    // Load extension: memory returns the addressed byte in bits 63:56.
    // ------------------------------------------------------------------
    always_comb begin
        w_load_ext = '0;
        case (r_funct3[1:0])
            2'b00: w_load_ext = r_funct3[2]
                ? {56'd0, bus.mem_rdata[63:56]}
                : {{56{bus.mem_rdata[63]}}, bus.mem_rdata[63:56]};
            2'b01: w_load_ext = r_funct3[2]
                ? {48'd0, bus.mem_rdata[63:48]}
                : {{48{bus.mem_rdata[63]}}, bus.mem_rdata[63:48]};
            2'b10: w_load_ext = r_funct3[2]
                ? {32'd0, bus.mem_rdata[63:32]}
                : {{32{bus.mem_rdata[63]}}, bus.mem_rdata[63:32]};
            default: w_load_ext = bus.mem_rdata;
        endcase
    end

    // Sub-word store merge: new bytes at the top, remaining bytes of the
    // doubleword read back unchanged.
    always_comb begin
        w_merged = '0;
        case (r_funct3[1:0])
            2'b00:   w_merged = {r_wdata[7:0],  bus.mem_rdata[55:0]};
            2'b01:   w_merged = {r_wdata[15:0], bus.mem_rdata[47:0]};
            default: w_merged = {r_wdata[31:0], bus.mem_rdata[31:0]};
        endcase
    end

    // ------------------------------------------------------------------
    // Control FSM with registered outputs. Strobes are raised on entry to
    // a memory state so they are high for exactly that state's cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_funct3     <= 3'd0;
            r_wdata      <= 32'd0;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_data  <= 64'd0;
            r_resp_fault <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_addr   <= 64'd0;
            r_mem_wdata  <= 64'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_req_ready  <= 1'b0;
                        r_funct3     <= bus.req_funct3;
                        r_wdata      <= bus.req_wdata[31:0];
                        r_resp_fault <= 1'b0;
                        if (w_fault) begin
                            r_resp_fault <= 1'b1;
                            r_resp_data  <= 64'd0;
                            r_resp_valid <= 1'b1;
                            r_state      <= RESP;
                        end else if (!bus.req_store) begin
                            r_mem_read <= 1'b1;
                            r_mem_addr <= bus.req_addr;
                            r_state    <= LOAD;
                        end else if (bus.req_funct3[1:0] == 2'b11) begin
                            r_mem_write <= 1'b1;
                            r_mem_addr  <= bus.req_addr;
                            r_mem_wdata <= bus.req_wdata;
                            r_state     <= WRITE;
                        end else begin
                            r_mem_read <= 1'b1;
                            r_mem_addr <= bus.req_addr;
                            r_state    <= RMW_RD;
                        end
                    end
                end
                LOAD: begin
                    r_mem_read   <= 1'b0;
                    r_resp_data  <= w_load_ext;
                    r_resp_valid <= 1'b1;
                    r_state      <= RESP;
                end
                RMW_RD: begin
                    r_mem_read  <= 1'b0;
                    r_mem_write <= 1'b1;
                    r_mem_wdata <= w_merged;
                    r_state     <= WRITE;
                end
                WRITE: begin
                    r_mem_write  <= 1'b0;
                    r_resp_data  <= 64'd0;
                    r_resp_valid <= 1'b1;
                    r_state      <= RESP;
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_req_ready  <= 1'b1;
                        r_state      <= IDLE;
                    end
                end
                default: begin
                    r_state      <= IDLE;
                    r_req_ready  <= 1'b1;
                    r_resp_valid <= 1'b0;
                    r_mem_read   <= 1'b0;
                    r_mem_write  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready  = r_req_ready;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_data  = r_resp_data;
    assign bus.resp_fault = r_resp_fault;
    assign bus.mem_read   = r_mem_read;
    assign bus.mem_write  = r_mem_write;
    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_wdata  = r_mem_wdata;

endmodule
`default_nettype wire
